alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer_if.sv | 22 ++
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Byte streams of the ALU sequencer: command bytes in, result bytes out.
// The sequencer takes the slave view; the command source / result sink takes the master view.
interface alu_sequencer_if;
  // A byte moves on a rising edge when its valid and ready are both high.
  // The valid side holds its byte steady until that edge.
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Byte-serial front end for the 16-bit ALU: gathers a 5-byte command, runs one execute cycle
// and streams the result back. Define ALU_SEQ_FLAGS_EN to add a third {overf, zerof} result byte.
module alu_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_sequencer_if.slave       bus,
  output logic                 busy,
  output logic [7:0]           alu_op,
  output logic [7:0]           alu_a_low,
  output logic [7:0]           alu_a_high,
  output logic [7:0]           alu_b_low,
  output logic [7:0]           alu_b_high,
  input  logic [7:0]           alu_res_low,
  input  logic [7:0]           alu_res_high,
  input  logic                 alu_zerof,
  input  logic                 alu_overf,
  output logic [3:0]           dbg_state
);

  typedef enum logic [3:0] {
    S_OP   = 4'd0,
    S_AL   = 4'd1,
    S_AH   = 4'd2,
    S_BL   = 4'd3,
    S_BH   = 4'd4,
    S_EXEC = 4'd5,
    S_RL   = 4'd6,
`ifdef ALU_SEQ_FLAGS_EN
    S_RH   = 4'd7,
    S_FL   = 4'd8
`else
    S_RH   = 4'd7
`endif
  } state_t;

  state_t     state;
  logic [7:0] op_q, a_low_q, a_high_q, b_low_q, b_high_q;
  logic [7:0] res_high_q;
  logic       in_ready_q, res_valid_q, busy_q;
  logic [7:0] res_data_q;
  logic       in_xfer, res_xfer;

`ifdef ALU_SEQ_FLAGS_EN
  logic zerof_q, overf_q;
`else
  logic unused_flags;
  assign unused_flags = alu_zerof ^ alu_overf;
`endif

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign res_xfer = res_valid_q & bus.res_ready;

  // res_data_q doubles as the captured low result byte while in S_RL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_OP;
      op_q        <= 8'h00;
      a_low_q     <= 8'h00;
      a_high_q    <= 8'h00;
      b_low_q     <= 8'h00;
      b_high_q    <= 8'h00;
      res_high_q  <= 8'h00;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      busy_q      <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zerof_q     <= 1'b0;
      overf_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_OP: if (in_xfer) begin
          op_q   <= bus.in_data;
          busy_q <= 1'b1;
          state  <= S_AL;
        end
        S_AL: if (in_xfer) begin
          a_low_q <= bus.in_data;
          state   <= S_AH;
        end
        S_AH: if (in_xfer) begin
          a_high_q <= bus.in_data;
          state    <= S_BL;
        end
        S_BL: if (in_xfer) begin
          b_low_q <= bus.in_data;
          state   <= S_BH;
        end
        S_BH: if (in_xfer) begin
          b_high_q   <= bus.in_data;
          in_ready_q <= 1'b0;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          res_data_q  <= alu_res_low;
          res_high_q  <= alu_res_high;
`ifdef ALU_SEQ_FLAGS_EN
          zerof_q     <= alu_zerof;
          overf_q     <= alu_overf;
`endif
          res_valid_q <= 1'b1;
          state       <= S_RL;
        end
        S_RL: if (res_xfer) begin
          res_data_q <= res_high_q;
          state      <= S_RH;
        end
`ifdef ALU_SEQ_FLAGS_EN
        S_RH: if (res_xfer) begin
          res_data_q <= {6'b0, overf_q, zerof_q};
          state      <= S_FL;
        end
        S_FL: if (res_xfer) begin
          res_valid_q <= 1'b0;
          res_data_q  <= 8'h00;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_OP;
        end
`else
        S_RH: if (res_xfer) begin
          res_valid_q <= 1'b0;
          res_data_q  <= 8'h00;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_OP;
        end
`endif
        default: begin
          res_valid_q <= 1'b0;
          res_data_q  <= 8'h00;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_OP;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign busy          = busy_q;
  assign alu_op        = op_q;
  assign alu_a_low     = a_low_q;
  assign alu_a_high    = a_high_q;
  assign alu_b_low     = b_low_q;
  assign alu_b_high    = b_high_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU stub and a byte scoreboard.
// Build with ALU_SEQ_FLAGS_EN defined to exercise the three-byte result format.
module tb_alu_sequencer;

  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [7:0] ALU_AND = 8'h03;
  localparam logic [7:0] ALU_OR  = 8'h04;
  localparam logic [7:0] ALU_XOR = 8'h05;
  localparam logic [7:0] ALU_EQ  = 8'h06;
`ifdef ALU_SEQ_FLAGS_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] alu_op, alu_a_low, alu_a_high, alu_b_low, alu_b_high;
  logic [7:0] alu_res_low, alu_res_high;
  logic       alu_zerof, alu_overf;
  logic [3:0] dbg_state;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .busy         (busy),
    .alu_op       (alu_op),
    .alu_a_low    (alu_a_low),
    .alu_a_high   (alu_a_high),
    .alu_b_low    (alu_b_low),
    .alu_b_high   (alu_b_high),
    .alu_res_low  (alu_res_low),
    .alu_res_high (alu_res_high),
    .alu_zerof    (alu_zerof),
    .alu_overf    (alu_overf),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU behaviour: {overf, zerof, result[15:0]} ----------------
  function automatic logic [17:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        ov, z;
    s = 17'd0; r = 16'd0; ov = 1'b0; z = 1'b0;
    case (op)
      ALU_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; ov = s[16]; end
      ALU_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; ov = s[16]; z = (r == 16'd0); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_EQ:  r = (a == b) ? 16'd1 : 16'd0;
      default: r = 16'd0;
    endcase
    return {ov, z, r};
  endfunction

  always_comb begin
    {alu_overf, alu_zerof, alu_res_high, alu_res_low} =
      alu_fn(alu_op, {alu_a_high, alu_a_low}, {alu_b_high, alu_b_low});
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [17:0] r;
    r = alu_fn(op, a, b);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
`ifdef ALU_SEQ_FLAGS_EN
    exp_q.push_back({6'b0, r[17], r[16]});
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int budget;
    repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 50) begin @(posedge clk); #1; budget++; end
    chk("in_ready_timeout", {15'd0, bus.in_ready}, 16'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic recv_bytes(input int n, input int max_stall);
    logic [7:0] exp;
    int budget;
    for (int i = 0; i < n; i++) begin
      budget = 0;
      while (bus.res_valid !== 1'b1 && budget < 50) begin @(posedge clk); #1; budget++; end
      chk("res_valid_timeout", {15'd0, bus.res_valid}, 16'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      repeat ($urandom_range(max_stall, 0)) begin
        @(posedge clk); #1;
        chk("res_hold", {8'd0, bus.res_data}, {8'd0, exp});
      end
      chk("res_byte", {8'd0, bus.res_data}, {8'd0, exp});
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
    end
  endtask

  // Full command; 'hold' cycles of backpressure in S_RL with ignored in_valid pulses.
  task automatic run_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int max_gap, input int max_stall, input int hold);
    push_expected(op, a, b);
    send_byte(op, max_gap);
    send_byte(a[7:0], max_gap);
    send_byte(a[15:8], max_gap);
    send_byte(b[7:0], max_gap);
    send_byte(b[15:8], max_gap);
    chk("exec_res_valid", {15'd0, bus.res_valid}, 16'd0);
    chk("exec_in_ready", {15'd0, bus.in_ready}, 16'd0);
    chk("exec_busy", {15'd0, busy}, 16'd1);
    @(posedge clk); #1;
    chk("latency_res_valid", {15'd0, bus.res_valid}, 16'd1);
    repeat (hold) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
      chk("bp_res_valid", {15'd0, bus.res_valid}, 16'd1);
      chk("bp_res_data", {8'd0, bus.res_data}, {8'd0, exp_q[0]});
    end
    bus.in_valid = 1'b0;
    chk("operand_a", {alu_a_high, alu_a_low}, a);
    chk("operand_b", {alu_b_high, alu_b_low}, b);
    chk("operand_op", {8'd0, alu_op}, {8'd0, op});
    recv_bytes(NBYTES, max_stall);
    chk("done_busy", {15'd0, busy}, 16'd0);
    chk("done_in_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("done_res_valid", {15'd0, bus.res_valid}, 16'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {15'd0, bus.in_ready}, 16'd1);
    chk({tag, "_res_valid"}, {15'd0, bus.res_valid}, 16'd0);
    chk({tag, "_res_data"}, {8'd0, bus.res_data}, 16'd0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_alu_op"}, {8'd0, alu_op}, 16'd0);
    chk({tag, "_alu_a"}, {alu_a_high, alu_a_low}, 16'd0);
    chk({tag, "_alu_b"}, {alu_b_high, alu_b_low}, 16'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] ops [7];
    logic [7:0] op;
    ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_AND; ops[3] = ALU_OR;
    ops[4] = ALU_XOR; ops[5] = ALU_EQ;  ops[6] = 8'hEE;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD, no stalls
    run_cmd(ALU_ADD, 16'h1234, 16'h0101, 0, 0, 0);
    // overflow
    run_cmd(ALU_ADD, 16'hFFFF, 16'h0001, 0, 0, 0);
    // EQ true / false
    run_cmd(ALU_EQ, 16'hABCD, 16'hABCD, 0, 0, 0);
    run_cmd(ALU_EQ, 16'hABCD, 16'hABCE, 0, 0, 0);
    // SUB to zero
    run_cmd(ALU_SUB, 16'h5A5A, 16'h5A5A, 0, 0, 0);
    // backpressure with ignored input pulses
    run_cmd(ALU_ADD, 16'h1234, 16'h0101, 0, 0, 3);
    // input gaps, same ADD
    run_cmd(ALU_ADD, 16'h1234, 16'h0101, 4, 0, 0);
    // unknown opcode
    run_cmd(8'hEE, 16'h1111, 16'h2222, 0, 0, 0);

    // reset in the middle of a command
    send_byte(ALU_ADD, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    chk("mid_busy", {15'd0, busy}, 16'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_res_valid", {15'd0, bus.res_valid}, 16'd0);
    chk("post_reset_busy", {15'd0, busy}, 16'd0);
    run_cmd(ALU_ADD, 16'h1234, 16'h0101, 0, 0, 0);

    // randomized commands with gaps and result stalls
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(6, 0)];
      if (op == 8'hEE) op = 8'($urandom);
      run_cmd(op, 16'($urandom), 16'($urandom), 4, 3, $urandom_range(2, 0));
    end

    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
